raster_dispatcher: RTL and testbench

- Distributes the transformed-vertex stream across NUM_RAST parallel rasterizer instances, one whole triangle at a time.
- Sits between the vertex/projection stage and the rasterizer bank.
- Buffers one vertex and picks a free rasterizer round-robin at each triangle start. It then locks that rasterizer until all three vertices are delivered.
- Fragment outputs of the bank are merged elsewhere; this block only sequences the input side.

---
 rtl/raster_pkg.sv | 22 ++
 rtl/rr_picker.sv | 36 +++
 rtl/raster_dispatcher.sv | 111 +++++++++++
 tb/tb_raster_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raster_pkg: shared types for the raster dispatch path                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package raster_pkg;

  localparam int VERTS_PER_TRI = 3;

  typedef struct packed {
    logic [3:0][31:0] position;
    logic [2:0][31:0] normal;
    logic [11:0]      material;
  } vertex_t;

  typedef enum logic [0:0] {
    ST_SELECT = 1'b0,
    ST_SEND   = 1'b1
  } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker: combinational round-robin first-requester finder          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand [NUM_REQ];

  // w_cand[k] is the index k positions after the start pointer, wrapped
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign w_cand[k] = IDX_W'((int'(i_start) + k) % NUM_REQ);
  end

  // Scan from the far end so the candidate nearest the start wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/raster_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | raster_dispatcher: feeds whole triangles to a bank of rasterizers    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module raster_dispatcher
  import raster_pkg::*;
#(
  parameter  int NUM_RAST = 2,
  localparam int SEL_W    = $clog2(NUM_RAST)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [3:0][31:0]      position_in,
  input  logic [2:0][31:0]      normal_in,
  input  logic [11:0]           material_in,
  output logic [NUM_RAST-1:0]   rast_valid_out,
  input  logic [NUM_RAST-1:0]   rast_ready_in,
  output logic [3:0][31:0]      rast_position_out,
  output logic [2:0][31:0]      rast_normal_out,
  output logic [11:0]           rast_material_out,
  output logic [SEL_W-1:0]      active_rast_out,
  output logic [15:0]           triangle_count_out,
  output logic                  idle_out
);

  localparam logic [SEL_W-1:0] c_LAST_IDX  = SEL_W'(NUM_RAST - 1);
  localparam logic [1:0]       c_LAST_VERT = 2'(VERTS_PER_TRI - 1);

  disp_state_e      r_state, w_state_nxt;
  vertex_t          r_buf;
  logic             r_buf_full;
  logic [SEL_W-1:0] r_active;
  logic [SEL_W-1:0] r_rr;
  logic [1:0]       r_vidx;
  logic [15:0]      r_tri_cnt;
  logic             r_idle;

  logic             w_found;
  logic [SEL_W-1:0] w_pick;
  logic             w_accept;
  logic             w_xfer;
  logic             w_last_xfer;

  rr_picker #(.NUM_REQ(NUM_RAST)) u_picker (
    .i_req   (rast_ready_in),
    .i_start (r_rr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign ready_out   = rst_in && !r_buf_full;
  assign w_accept    = valid_in && ready_out;
  assign w_xfer      = (r_state == ST_SEND) && r_buf_full && rast_ready_in[r_active];
  assign w_last_xfer = w_xfer && (r_vidx == c_LAST_VERT);

  always_comb begin
    w_state_nxt    = r_state;
    rast_valid_out = '0;
    case (r_state)
      ST_SELECT: if (r_buf_full && w_found) w_state_nxt = ST_SEND;
      ST_SEND: begin
        rast_valid_out[r_active] = r_buf_full;
        if (w_last_xfer) w_state_nxt = ST_SELECT;
      end
      default: w_state_nxt = ST_SELECT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= ST_SELECT;
      r_buf_full <= 1'b0;
      r_active   <= '0;
      r_rr       <= '0;
      r_vidx     <= '0;
      r_tri_cnt  <= '0;
      r_idle     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf      <= '{position: position_in, normal: normal_in, material: material_in};
      end else if (w_xfer) begin
        r_buf_full <= 1'b0;
      end
      if (r_state == ST_SELECT && r_buf_full && w_found) r_active <= w_pick;
      // The rotation point moves only when a triangle completes
      if (w_last_xfer) begin
        r_vidx    <= '0;
        r_rr      <= (r_active == c_LAST_IDX) ? '0 : r_active + 1'b1;
        r_tri_cnt <= r_tri_cnt + 16'd1;
      end else if (w_xfer) begin
        r_vidx <= r_vidx + 2'd1;
      end
      r_idle <= !r_buf_full && (r_state == ST_SELECT) && (&rast_ready_in);
    end
  end

  // Data registers carry no reset; r_buf_full qualifies them
  assign rast_position_out  = r_buf.position;
  assign rast_normal_out    = r_buf.normal;
  assign rast_material_out  = r_buf.material;
  assign active_rast_out    = r_active;
  assign triangle_count_out = r_tri_cnt;
  assign idle_out           = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_raster_dispatcher.sv
`default_nettype none
// Scoreboard bench for raster_dispatcher: random vertices and rasterizer
// readiness, checked against a triangle-level dispatch model.
module tb_raster_dispatcher;
  import raster_pkg::*;

  localparam int N = 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             valid_in;
  logic             ready_out;
  logic [3:0][31:0] position_in;
  logic [2:0][31:0] normal_in;
  logic [11:0]      material_in;
  logic [N-1:0]     rast_valid_out;
  logic [N-1:0]     rast_ready_in = '0;
  logic [3:0][31:0] rast_position_out;
  logic [2:0][31:0] rast_normal_out;
  logic [11:0]      rast_material_out;
  logic [0:0]       active_rast_out;
  logic [15:0]      triangle_count_out;
  logic             idle_out;

  always #5 clk_in = ~clk_in;

  raster_dispatcher #(.NUM_RAST(N)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .position_in(position_in), .normal_in(normal_in), .material_in(material_in),
    .rast_valid_out(rast_valid_out), .rast_ready_in(rast_ready_in),
    .rast_position_out(rast_position_out), .rast_normal_out(rast_normal_out),
    .rast_material_out(rast_material_out), .active_rast_out(active_rast_out),
    .triangle_count_out(triangle_count_out), .idle_out(idle_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int first_ready(logic [N-1:0] mask, int start);
    for (int k = 0; k < N; k++)
      if (mask[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Reference model state
  vertex_t      exp_q[$];
  int           m_vidx = 0, m_rr = 0, m_dest = 0;
  logic [15:0]  m_cnt = '0;
  logic [N-1:0] prev_valid = '0, prev_ready = '0;
  vertex_t      prev_data;
  logic [N-1:0] pend_xfer = '0;
  bit           pend_last = 0, pend_rst = 1;
  int           bit1_hits = 0;
  logic [N-1:0] xf;
  vertex_t      cur;

  // Rasterizer bank model
  int           busy[N];
  logic [N-1:0] dis = '0, hold = '0;
  bit           rand_stall = 0;

  always @(posedge clk_in) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_rst) busy[i] = 0;
      else begin
        if (busy[i] > 0) busy[i]--;
        if (pend_xfer[i]) busy[i] = pend_last ? int'($urandom_range(12, 3)) : 2;
      end
      rast_ready_in[i] = !dis[i] && !hold[i] && busy[i] == 0 &&
                         (!rand_stall || $urandom_range(3, 0) != 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk_in) begin
    cur = '{position: rast_position_out, normal: rast_normal_out, material: rast_material_out};
    if (!rst_in) begin
      exp_q.delete();
      m_vidx = 0; m_rr = 0; m_cnt = '0;
      pend_xfer = '0; pend_last = 0; pend_rst = 1;
      prev_valid = '0;
    end else begin
      pend_rst = 0;
      check("tri_count", 256'(triangle_count_out), 256'(m_cnt));
      if (rast_valid_out != '0) begin
        check("onehot", 256'($countones(rast_valid_out)), 256'(1));
        check("ready_out_when_full", 256'(ready_out), 256'(0));
        check("active_idx", 256'(active_rast_out), 256'(onehot_idx(rast_valid_out)));
        if (rast_valid_out[1]) bit1_hits++;
      end
      if (prev_valid != '0 && (prev_valid & prev_ready) == '0) begin
        check("hold_valid", 256'(rast_valid_out), 256'(prev_valid));
        check("hold_data", 256'(cur), 256'(prev_data));
      end
      if (rast_valid_out != '0 && prev_valid == '0 && m_vidx == 0) begin
        m_dest = first_ready(prev_ready, m_rr);
        check("select_idx", 256'(onehot_idx(rast_valid_out)), 256'(m_dest));
      end
      xf = rast_valid_out & rast_ready_in;
      pend_xfer = xf;
      pend_last = 0;
      if (xf != '0) begin
        check("dest_locked", 256'(onehot_idx(xf)), 256'(m_dest));
        if (exp_q.size() == 0) check("unexpected_vertex", 256'(1), 256'(0));
        else check("payload", 256'(cur), 256'(exp_q.pop_front()));
        if (m_vidx == VERTS_PER_TRI - 1) begin
          m_vidx = 0; m_rr = (m_dest + 1) % N; m_cnt++; pend_last = 1;
        end else m_vidx++;
      end
      prev_valid = rast_valid_out;
    end
    prev_ready = rast_ready_in;
    prev_data  = cur;
  end

  task automatic send_vertex();
    vertex_t v;
    bit ok = 0;
    for (int i = 0; i < 4; i++) v.position[i] = $urandom;
    for (int i = 0; i < 3; i++) v.normal[i] = $urandom;
    v.material = 12'($urandom);
    valid_in = 1'b1;
    position_in = v.position; normal_in = v.normal; material_in = v.material;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk_in);
      if (ready_out && rst_in) begin exp_q.push_back(v); ok = 1; end
    end
    if (!ok) check("accept_timeout", 256'(0), 256'(1));
    @(posedge clk_in); #2;
    valid_in = 1'b0;
  endtask

  task automatic send_tris(int n, int max_gap);
    for (int t = 0; t < n * VERTS_PER_TRI; t++) begin
      send_vertex();
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk_in); #2; end
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && m_vidx == 0 && rast_valid_out == '0) ok = 1;
    end
    if (!ok) check("drain_timeout", 256'(0), 256'(1));
    @(posedge clk_in); #2;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk_in);
      if (idle_out) ok = 1;
    end
    if (!ok) check("idle_timeout", 256'(0), 256'(1));
    @(posedge clk_in); #2;
  endtask

  task automatic wait_vidx(int target);
    bit ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk_in);
      if (m_vidx == target) ok = 1;
    end
    if (!ok) check("vidx_timeout", 256'(0), 256'(1));
    @(posedge clk_in); #2;
  endtask

  initial begin
    logic [N-1:0]     expv;
    logic [3:0][31:0] held_pos;
    rst_in = 1'b0; valid_in = 1'b0;
    position_in = '0; normal_in = '0; material_in = '0;
    repeat (3) @(posedge clk_in);
    #2;
    @(negedge clk_in);
    check("rst_ready_out", 256'(ready_out), 256'(0));
    check("rst_valid", 256'(rast_valid_out), 256'(0));
    check("rst_active", 256'(active_rast_out), 256'(0));
    check("rst_count", 256'(triangle_count_out), 256'(0));
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    wait_idle();

    // One triangle, then two back-to-back, all rasterizers ready
    send_tris(1, 0);
    drain();
    check("count_after_1", 256'(triangle_count_out), 256'(1));
    check("no_bit1_first_tri", 256'(bit1_hits), 256'(0));
    send_tris(2, 0);
    drain();
    check("count_after_3", 256'(triangle_count_out), 256'(3));

    // Rasterizer 1 permanently busy
    dis = 2'b10; bit1_hits = 0;
    send_tris(3, 1);
    drain();
    check("bit1_never_used", 256'(bit1_hits), 256'(0));
    check("count_after_6", 256'(triangle_count_out), 256'(6));
    dis = '0;

    // Long stall between vertex 1 and 2 of a triangle
    wait_idle();
    send_vertex(); send_vertex();
    wait_vidx(2);
    hold = '1;
    send_vertex();
    @(negedge clk_in);
    expv = N'(1) << m_dest;
    held_pos = rast_position_out;
    for (int c = 0; c < 10; c++) begin
      check("stall_valid", 256'(rast_valid_out), 256'(expv));
      check("stall_pos", 256'(rast_position_out), 256'(held_pos));
      check("stall_ready_out", 256'(ready_out), 256'(0));
      @(negedge clk_in);
    end
    @(posedge clk_in); #2;
    hold = '0;
    drain();
    check("count_after_7", 256'(triangle_count_out), 256'(7));

    // Randomized traffic with random rasterizer stalls
    rand_stall = 1;
    send_tris(15, 3);
    drain();
    rand_stall = 0;
    check("count_after_22", 256'(triangle_count_out), 256'(22));

    // Reset in the middle of a triangle
    wait_idle();
    send_vertex();
    wait_vidx(1);
    rst_in = 1'b0;
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst_valid", 256'(rast_valid_out), 256'(0));
    check("midrst_count", 256'(triangle_count_out), 256'(0));
    @(posedge clk_in); #2;
    wait_idle();
    send_tris(1, 0);
    drain();
    check("count_after_rst", 256'(triangle_count_out), 256'(1));

    // Counter wrap through 0xFFFF
    wait_idle();
    force dut.r_tri_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1 release dut.r_tri_cnt;
    send_tris(3, 1);
    drain();
    check("count_wrapped", 256'(triangle_count_out), 256'(16'h0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
